// File: rtl/cfg_bus_pkg.sv
// Shared definitions for the cfg_cs_n/cfg_ack_n four-phase register bus.
// Used by the bus master and by the responders that sit on the bus.
package cfg_bus_pkg;

  localparam int CFG_AW = 32;
  localparam int CFG_DW = 32;

  localparam logic CFG_RW_WRITE = 1'b0;
  localparam logic CFG_RW_READ  = 1'b1;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SETUP    = 3'd1,
    WAIT_ACK = 3'd2,
    WAIT_REL = 3'd3,
    RESP     = 3'd4
  } cfg_state_e;

endpackage

// File: rtl/cfg_ack_sync.sv
// Two-flop synchronizer for the asynchronous low-active responder ack.
// Both flops reset to 1 so the bus looks idle straight out of reset.
module cfg_ack_sync (
  input  logic clk,
  input  logic rst,
  input  logic ack_n_i,
  output logic ack_s_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= ack_n_i;
      sync_q <= meta_q;
    end
  end

  assign ack_s_o = sync_q;

endmodule

// File: rtl/cfg_bus_master.sv
// Initiator for the four-phase cfg register bus: accepts one command, runs one
// cs_n/ack_n transaction, returns read data or a timeout flag.
module cfg_bus_master
  import cfg_bus_pkg::*;
#(
  parameter int SETUP_CYC   = 2,
  parameter int TIMEOUT_CYC = 1024,
  parameter int TO_W        = 11
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_rw,
  input  logic [CFG_AW-1:0] cmd_addr,
  input  logic [CFG_DW-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [CFG_DW-1:0] rsp_rdata,
  output logic              rsp_timeout,
  output logic              cfg_cs_n,
  input  logic              cfg_ack_n,
  output logic              cfg_rw,
  output logic [CFG_AW-1:0] cfg_addr,
  output logic [CFG_DW-1:0] cfg_wdata,
  input  logic [CFG_DW-1:0] cfg_rdata
);

  localparam logic [TO_W-1:0] SETUP_LAST = TO_W'(SETUP_CYC - 1);
  localparam logic [TO_W-1:0] TO_LAST    = TO_W'(TIMEOUT_CYC - 1);

  cfg_state_e        state_q;
  logic [TO_W-1:0]   cnt_q;
  logic              cmd_ready_q;
  logic              rsp_valid_q;
  logic [CFG_DW-1:0] rsp_rdata_q;
  logic              rsp_timeout_q;
  logic              cfg_cs_n_q;
  logic              cfg_rw_q;
  logic [CFG_AW-1:0] cfg_addr_q;
  logic [CFG_DW-1:0] cfg_wdata_q;
  logic              ack_s;

  cfg_ack_sync u_ack_sync (
    .clk     (clk),
    .rst     (rst),
    .ack_n_i (cfg_ack_n),
    .ack_s_o (ack_s)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      cmd_ready_q   <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_timeout_q <= 1'b0;
      cfg_cs_n_q    <= 1'b1;
      cfg_rw_q      <= CFG_RW_WRITE;
      cfg_addr_q    <= '0;
      cfg_wdata_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          cmd_ready_q <= 1'b1;
          cfg_cs_n_q  <= 1'b1;
          if (cmd_ready_q && cmd_valid) begin
            cfg_rw_q    <= cmd_rw;
            cfg_addr_q  <= cmd_addr;
            cfg_wdata_q <= cmd_wdata;
            cmd_ready_q <= 1'b0;
            cnt_q       <= '0;
            state_q     <= SETUP;
          end
        end
        SETUP: begin
          // A stale ack (still low from a previous responder cycle) blocks
          // cs_n assertion; if it never clears the command times out here.
          if (cnt_q >= SETUP_LAST && ack_s) begin
            cfg_cs_n_q <= 1'b0;
            cnt_q      <= '0;
            state_q    <= WAIT_ACK;
          end else if (cnt_q == TO_LAST) begin
            rsp_rdata_q   <= '0;
            rsp_timeout_q <= 1'b1;
            cnt_q         <= '0;
            state_q       <= WAIT_REL;
          end else begin
            cnt_q <= cnt_q + TO_W'(1);
          end
        end
        WAIT_ACK: begin
          if (!ack_s) begin
            rsp_rdata_q   <= (cfg_rw_q == CFG_RW_READ) ? cfg_rdata : '0;
            rsp_timeout_q <= 1'b0;
            cfg_cs_n_q    <= 1'b1;
            cnt_q         <= '0;
            state_q       <= WAIT_REL;
          end else if (cnt_q == TO_LAST) begin
            rsp_rdata_q   <= '0;
            rsp_timeout_q <= 1'b1;
            cfg_cs_n_q    <= 1'b1;
            cnt_q         <= '0;
            state_q       <= WAIT_REL;
          end else begin
            cnt_q <= cnt_q + TO_W'(1);
          end
        end
        WAIT_REL: begin
          cfg_cs_n_q <= 1'b1;
          if (ack_s || cnt_q == TO_LAST) begin
            rsp_valid_q <= 1'b1;
            cnt_q       <= '0;
            state_q     <= RESP;
          end else begin
            cnt_q <= cnt_q + TO_W'(1);
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            cmd_ready_q <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          cmd_ready_q <= 1'b0;
          rsp_valid_q <= 1'b0;
          cfg_cs_n_q  <= 1'b1;
          cnt_q       <= '0;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign cmd_ready   = cmd_ready_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_timeout = rsp_timeout_q;
  assign cfg_cs_n    = cfg_cs_n_q;
  assign cfg_rw      = cfg_rw_q;
  assign cfg_addr    = cfg_addr_q;
  assign cfg_wdata   = cfg_wdata_q;

endmodule

// File: tb/tb_cfg_bus_master.sv
// Bench for cfg_bus_master: a responder model on the bus, a register-file
// reference model producing expected responses, and directed plus random commands.
module tb_cfg_bus_master;

  localparam int SETUP_CYC   = 2;
  localparam int TIMEOUT_CYC = 16;
  localparam int TO_W        = 5;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        cmd_valid, cmd_ready, cmd_rw;
  logic [31:0] cmd_addr, cmd_wdata;
  logic        rsp_valid, rsp_ready, rsp_timeout;
  logic [31:0] rsp_rdata;
  logic        cfg_cs_n, cfg_ack_n, cfg_rw;
  logic [31:0] cfg_addr, cfg_wdata, cfg_rdata;

  cfg_bus_master #(
    .SETUP_CYC   (SETUP_CYC),
    .TIMEOUT_CYC (TIMEOUT_CYC),
    .TO_W        (TO_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_rw      (cmd_rw),
    .cmd_addr    (cmd_addr),
    .cmd_wdata   (cmd_wdata),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_rdata   (rsp_rdata),
    .rsp_timeout (rsp_timeout),
    .cfg_cs_n    (cfg_cs_n),
    .cfg_ack_n   (cfg_ack_n),
    .cfg_rw      (cfg_rw),
    .cfg_addr    (cfg_addr),
    .cfg_wdata   (cfg_wdata),
    .cfg_rdata   (cfg_rdata)
  );

  // ---------------- checking ----------------
  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- responder model ----------------
  logic [31:0] resp_mem [256];
  bit          resp_on = 1'b1;
  bit          stale   = 1'b0;
  int          lo_cnt  = 0;
  int          hi_cnt  = 0;

  always @(negedge clk) begin
    if (stale) begin
      cfg_ack_n = 1'b0;
    end else if (!resp_on) begin
      cfg_ack_n = 1'b1;
      cfg_rdata = 32'hDEADBEEF;
      lo_cnt = 0;
      hi_cnt = 0;
    end else if (!cfg_cs_n) begin
      hi_cnt = 0;
      if (cfg_ack_n) begin
        lo_cnt++;
        if (lo_cnt >= 3) begin
          cfg_ack_n = 1'b0;
          if (!cfg_rw) resp_mem[cfg_addr[9:2]] = cfg_wdata;
          cfg_rdata = resp_mem[cfg_addr[9:2]];
        end
      end
    end else begin
      lo_cnt = 0;
      if (!cfg_ack_n) begin
        hi_cnt++;
        if (hi_cnt >= 2) begin
          cfg_ack_n = 1'b1;
          cfg_rdata = 32'hDEADBEEF;
          hi_cnt = 0;
        end
      end
    end
  end

  // ---------------- bus monitor ----------------
  logic        cs_prev     = 1'b1;
  int          fall_cyc    = 0;
  int          low_cnt     = 0;
  int          fall_count  = 0;
  logic        ack_at_fall = 1'b1;
  int          stab_err    = 0;
  int          acc_cyc     = 0;
  logic        cur_rw;
  logic [31:0] cur_addr, cur_wdata;

  always @(negedge clk) begin
    if (!cfg_cs_n) begin
      if (cs_prev) begin
        fall_cyc    = cyc;
        low_cnt     = 0;
        fall_count++;
        ack_at_fall = cfg_ack_n;
      end
      low_cnt++;
      if (cfg_rw !== cur_rw || cfg_addr !== cur_addr || cfg_wdata !== cur_wdata) stab_err++;
    end
    cs_prev = cfg_cs_n;
  end

  // ---------------- reference model + scoreboard ----------------
  logic [31:0] ref_mem [256];
  logic [32:0] exp_q [$];

  // {timeout, rdata} the master must report for one command
  function automatic logic [32:0] model(input logic rw, input logic [31:0] addr,
                                        input logic [31:0] wdata, input bit responds);
    if (!responds) return {1'b1, 32'h0};
    if (rw == 1'b0) begin
      ref_mem[addr[9:2]] = wdata;
      return {1'b0, 32'h0};
    end
    return {1'b0, ref_mem[addr[9:2]]};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic issue(input logic rw, input logic [31:0] addr, input logic [31:0] wdata);
    int n = 0;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_rw    = rw;
    cmd_addr  = addr;
    cmd_wdata = wdata;
    cur_rw    = rw;
    cur_addr  = addr;
    cur_wdata = wdata;
    while (!cmd_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("cmd_accept", cmd_ready, 1);
    @(posedge clk);
    #1;
    acc_cyc   = cyc;
    cmd_valid = 1'b0;
    cmd_rw    = 1'($urandom);
    cmd_addr  = $urandom;
    cmd_wdata = $urandom;
  endtask

  task automatic collect(input int hold);
    int n = 0;
    logic [32:0] first;
    logic [32:0] exp;
    while (!rsp_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("rsp_valid_seen", rsp_valid, 1);
    first = {rsp_timeout, rsp_rdata};
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("rsp_hold", {rsp_valid, rsp_timeout, rsp_rdata}, {1'b1, first});
      chk("cmd_ready_busy", cmd_ready, 0);
    end
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : 33'h1_FFFF_FFFF;
    chk("rsp_data", {rsp_timeout, rsp_rdata}, exp);
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    chk("rsp_drop", rsp_valid, 0);
  endtask

  task automatic run_txn(input logic rw, input logic [31:0] addr, input logic [31:0] wdata,
                         input int hold);
    int  falls0;
    bit  responds;
    falls0   = fall_count;
    stab_err = 0;
    responds = resp_on && !stale;
    exp_q.push_back(model(rw, addr, wdata, responds));
    issue(rw, addr, wdata);
    collect(hold);
    if (responds) begin
      chk("setup_cycles", 64'(fall_cyc - acc_cyc), 64'(SETUP_CYC));
      chk("ack_idle_at_cs", ack_at_fall, 1);
      chk("one_cs_pulse", 64'(fall_count - falls0), 1);
    end else if (!stale) begin
      chk("to_cs_low_cycles", 64'(low_cnt), 64'(TIMEOUT_CYC));
      chk("one_cs_pulse", 64'(fall_count - falls0), 1);
    end else begin
      chk("stale_no_cs", 64'(fall_count - falls0), 0);
    end
    chk("pins_stable", 64'(stab_err), 0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int n;
    bit seen;
    int falls0;
    for (int i = 0; i < 256; i++) begin
      resp_mem[i] = 32'((i * 4) << 8) | 32'hD4;
      ref_mem[i]  = resp_mem[i];
    end
    cmd_valid = 1'b0;
    cmd_rw    = 1'b0;
    cmd_addr  = '0;
    cmd_wdata = '0;
    rsp_ready = 1'b0;
    cfg_ack_n = 1'b1;
    cfg_rdata = 32'hDEADBEEF;
    cur_rw    = 1'b0;
    cur_addr  = '0;
    cur_wdata = '0;

    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cmd_ready", cmd_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_rdata", rsp_rdata, 0);
    chk("rst_rsp_timeout", rsp_timeout, 0);
    chk("rst_cs_n", cfg_cs_n, 1);
    chk("rst_cfg_rw", cfg_rw, 0);
    chk("rst_cfg_addr", cfg_addr, 0);
    chk("rst_cfg_wdata", cfg_wdata, 0);
    @(negedge clk);
    rst = 1'b0;

    // write, then reads including the written location
    run_txn(1'b0, 32'h0, 32'h05, 0);
    run_txn(1'b1, 32'h30, 32'h0, 0);
    run_txn(1'b1, 32'h0, 32'h0, 1);

    // held response with a second command waiting
    falls0 = fall_count;
    exp_q.push_back(model(1'b1, 32'h14, 32'h0, 1'b1));
    stab_err = 0;
    issue(1'b1, 32'h14, 32'h0);
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_rw    = 1'b0;
    cmd_addr  = 32'h20;
    cmd_wdata = 32'h1234;
    collect(10);
    cmd_valid = 1'b0;
    chk("no_second_cs", 64'(fall_count - falls0), 1);
    chk("held_pins_stable", 64'(stab_err), 0);

    // no responder
    resp_on = 1'b0;
    run_txn(1'b1, 32'h44, 32'h0, 0);
    resp_on = 1'b1;

    // ack stuck low before cs_n
    stale = 1'b1;
    repeat (4) @(negedge clk);
    run_txn(1'b1, 32'h48, 32'h0, 0);
    stale = 1'b0;
    repeat (4) @(negedge clk);

    // reset while waiting for ack
    issue(1'b1, 32'h10, 32'h0);
    n = 0;
    while (cfg_cs_n && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("cs_low_before_rst", cfg_cs_n, 0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("abort_cs_n", cfg_cs_n, 1);
    chk("abort_rsp_valid", rsp_valid, 0);
    chk("abort_cmd_ready", cmd_ready, 0);
    @(negedge clk);
    rst  = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (rsp_valid) seen = 1'b1;
    end
    chk("abort_no_rsp", seen, 0);
    run_txn(1'b1, 32'h10, 32'h0, 0);

    // back-to-back reads
    run_txn(1'b1, 32'h8, 32'h0, 0);
    run_txn(1'b1, 32'hC, 32'h0, 0);

    // random traffic
    for (int i = 0; i < 40; i++) begin
      logic        rw;
      logic [31:0] addr;
      resp_on = ($urandom_range(0, 7) != 0);
      rw      = 1'($urandom_range(0, 1));
      addr    = 32'($urandom_range(0, 15)) << 2;
      run_txn(rw, addr, $urandom, $urandom_range(0, 3));
    end
    resp_on = 1'b1;

    chk("exp_q_empty", 64'(exp_q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired at t=%0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
